// File: rtl/mem_bank_arbiter.sv
// Multi-bank dual-port memory arbiter: per-bank round-robin on the write and read ports,
// registered bank commands, fixed-latency read return through a per-bank tag pipeline.
module mem_bank_rr_arb #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  i_req,
  output logic [N-1:0]  o_gnt,
  output logic          o_gnt_vld,
  output logic [PW-1:0] o_gnt_idx
);
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_j;

  // first requester at or after the pointer, wrapping
  always_comb begin
    o_gnt     = '0;
    o_gnt_vld = 1'b0;
    o_gnt_idx = '0;
    w_j       = '0;
    for (int k = 0; k < N; k++) begin
      w_j = PW'((int'(r_ptr) + k) % N);
      if (!o_gnt_vld && i_req[w_j]) begin
        o_gnt[w_j] = 1'b1;
        o_gnt_vld  = 1'b1;
        o_gnt_idx  = w_j;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_ptr <= '0;
    else if (o_gnt_vld) r_ptr <= (int'(o_gnt_idx) == N-1) ? '0 : o_gnt_idx + 1'b1;
  end
endmodule

module mem_bank_arbiter #(
  parameter  int num_req             = 4,
  parameter  int num_banks           = 4,
  parameter  int entries_per_bank    = 8,
  parameter  int data_bit_width      = 32,
  localparam int bank_bits           = $clog2(num_banks),
  localparam int bank_addr_bit_width = $clog2(entries_per_bank),
  localparam int addr_bit_width      = bank_bits + bank_addr_bit_width
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [num_req-1:0]                       req_valid,
  output logic [num_req-1:0]                       req_ready,
  input  logic [num_req-1:0]                       req_we,
  input  logic [num_req*addr_bit_width-1:0]        req_addr,
  input  logic [num_req*data_bit_width-1:0]        req_wdata,
  output logic [num_req-1:0]                       rsp_valid,
  output logic [num_req*data_bit_width-1:0]        rsp_data,
  output logic [num_banks-1:0]                     bank_wr_en,
  output logic [num_banks*bank_addr_bit_width-1:0] bank_wr_addr,
  output logic [num_banks*data_bit_width-1:0]      bank_wr_data,
  output logic [num_banks-1:0]                     bank_rd_en,
  output logic [num_banks*bank_addr_bit_width-1:0] bank_rd_addr,
  input  logic [num_banks*data_bit_width-1:0]      bank_rd_data,
  output logic [15:0]                              stall_count
);
  localparam int PW  = (num_req > 1) ? $clog2(num_req) : 1;
  localparam int DW  = data_bit_width;
  localparam int BB  = bank_bits;
  localparam int BAW = bank_addr_bit_width;
  localparam int AW  = addr_bit_width;

  logic [num_req-1:0][AW-1:0]            w_addr;
  logic [num_req-1:0][DW-1:0]            w_wdata;
  logic [num_banks-1:0][DW-1:0]          w_rd;
  logic [num_banks-1:0][num_req-1:0]     w_wgnt, w_rgnt;
  logic [num_banks-1:0]                  w_rsp_vld;
  logic [num_banks-1:0][PW-1:0]          w_rsp_idx;
  logic [num_req-1:0]                    w_gnt;
  logic [num_req-1:0]                    r_rsp_valid;
  logic [num_req-1:0][DW-1:0]            r_rsp_data;
  logic [15:0]                           r_stall_count;

  assign w_addr  = req_addr;
  assign w_wdata = req_wdata;
  assign w_rd    = bank_rd_data;

  for (genvar b = 0; b < num_banks; b++) begin : g_bank
    logic [num_req-1:0]     w_wcand, w_rcand;
    logic                   w_wvld, w_rvld;
    logic [PW-1:0]          w_widx, w_ridx;
    logic                   r_wr_en, r_rd_en;
    logic [BAW-1:0]         r_wr_addr, r_rd_addr;
    logic [DW-1:0]          r_wr_data;
    logic [1:0]             r_vld_pipe;
    logic [1:0][PW-1:0]     r_tag_pipe;

    always_comb begin
      w_wcand = '0;
      w_rcand = '0;
      for (int i = 0; i < num_req; i++) begin
        w_wcand[i] = req_valid[i] &  req_we[i] & (w_addr[i][BB-1:0] == BB'(b));
        w_rcand[i] = req_valid[i] & ~req_we[i] & (w_addr[i][BB-1:0] == BB'(b));
      end
    end

    mem_bank_rr_arb #(.N(num_req), .PW(PW)) u_warb (
      .clk(clk), .rst_n(rst_n), .i_req(w_wcand),
      .o_gnt(w_wgnt[b]), .o_gnt_vld(w_wvld), .o_gnt_idx(w_widx));
    mem_bank_rr_arb #(.N(num_req), .PW(PW)) u_rarb (
      .clk(clk), .rst_n(rst_n), .i_req(w_rcand),
      .o_gnt(w_rgnt[b]), .o_gnt_vld(w_rvld), .o_gnt_idx(w_ridx));

    // addr/data hold when idle; only the enables follow the grant
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_wr_en    <= 1'b0;
        r_wr_addr  <= '0;
        r_wr_data  <= '0;
        r_rd_en    <= 1'b0;
        r_rd_addr  <= '0;
        r_vld_pipe <= '0;
        r_tag_pipe <= '0;
      end else begin
        r_wr_en <= w_wvld;
        if (w_wvld) begin
          r_wr_addr <= w_addr[w_widx][AW-1:BB];
          r_wr_data <= w_wdata[w_widx];
        end
        r_rd_en <= w_rvld;
        if (w_rvld) r_rd_addr <= w_addr[w_ridx][AW-1:BB];
        r_vld_pipe <= {r_vld_pipe[0], w_rvld};
        r_tag_pipe <= {r_tag_pipe[0], w_ridx};
      end
    end

    assign bank_wr_en[b]               = r_wr_en;
    assign bank_wr_addr[b*BAW +: BAW]  = r_wr_addr;
    assign bank_wr_data[b*DW +: DW]    = r_wr_data;
    assign bank_rd_en[b]               = r_rd_en;
    assign bank_rd_addr[b*BAW +: BAW]  = r_rd_addr;
    assign w_rsp_vld[b]                = r_vld_pipe[1];
    assign w_rsp_idx[b]                = r_tag_pipe[1];
  end

  // a request targets exactly one bank port, so at most one grant per requester
  always_comb begin
    w_gnt = '0;
    for (int b = 0; b < num_banks; b++) w_gnt = w_gnt | w_wgnt[b] | w_rgnt[b];
  end
  assign req_ready = {num_req{rst_n}} & w_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      for (int i = 0; i < num_req; i++) begin
        r_rsp_valid[i] <= 1'b0;
        for (int b = 0; b < num_banks; b++) begin
          if (w_rsp_vld[b] && w_rsp_idx[b] == PW'(i)) begin
            r_rsp_valid[i] <= 1'b1;
            r_rsp_data[i]  <= w_rd[b];
          end
        end
      end
    end
  end
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_count <= '0;
    else if (|(req_valid & ~req_ready) && r_stall_count != 16'hFFFF)
      r_stall_count <= r_stall_count + 16'd1;
  end
  assign stall_count = r_stall_count;
endmodule

// File: tb/tb_mem_bank_arbiter.sv
// Bench for mem_bank_arbiter: behavioural banks, read/command scoreboard, vector table,
// plus hand sequences for conflict/saturation and reset during an in-flight read.
module tb_mem_bank_arbiter;
  localparam int NR = 4, NB = 4, EPB = 8, DW = 32, BAW = 3, AW = 5;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic [NR-1:0]     req_valid = '0, req_we = '0;
  logic [NR*AW-1:0]  req_addr = '0;
  logic [NR*DW-1:0]  req_wdata = '0;
  logic [NR-1:0]     req_ready, rsp_valid;
  logic [NR*DW-1:0]  rsp_data;
  logic [NB-1:0]     bank_wr_en, bank_rd_en;
  logic [NB*BAW-1:0] bank_wr_addr, bank_rd_addr;
  logic [NB*DW-1:0]  bank_wr_data, bank_rd_data;
  logic [15:0]       stall_count;

  always #5 clk = ~clk;

  mem_bank_arbiter #(.num_req(NR), .num_banks(NB), .entries_per_bank(EPB), .data_bit_width(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .bank_wr_en(bank_wr_en), .bank_wr_addr(bank_wr_addr), .bank_wr_data(bank_wr_data),
    .bank_rd_en(bank_rd_en), .bank_rd_addr(bank_rd_addr), .bank_rd_data(bank_rd_data),
    .stall_count(stall_count));

  int errors = 0, checks = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // external banks: registered read, read-before-write on the same edge
  logic [DW-1:0] bmem [NB][EPB];
  logic [DW-1:0] rdq  [NB];
  logic [DW-1:0] ref_mem [NB*EPB];
  initial for (int b = 0; b < NB; b++) for (int e = 0; e < EPB; e++) bmem[b][e] <= 32'hA000_0000 + e*NB + b;
  always @(posedge clk)
    for (int b = 0; b < NB; b++) begin
      if (bank_rd_en[b]) rdq[b] <= bmem[b][bank_rd_addr[b*BAW +: BAW]];
      if (bank_wr_en[b]) bmem[b][bank_wr_addr[b*BAW +: BAW]] <= bank_wr_data[b*DW +: DW];
    end
  always_comb begin
    bank_rd_data = '0;
    for (int b = 0; b < NB; b++) bank_rd_data[b*DW +: DW] = rdq[b];
  end

  typedef struct { int rq; logic [DW-1:0] d; int due; } sb_t;
  sb_t sb[$];
  logic [NB-1:0]  pw_en = '0, pr_en = '0;
  logic [BAW-1:0] pw_a [NB], pr_a [NB];
  logic [DW-1:0]  pw_d [NB];

  initial begin : mon
    int hit;
    logic [AW-1:0] a;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        pw_en = '0;
        pr_en = '0;
      end else begin
        for (int i = 0; i < NR; i++) begin
          hit = -1;
          for (int s = 0; s < sb.size(); s++) if (hit < 0 && sb[s].rq == i) hit = s;
          if (hit >= 0 && sb[hit].due == cyc) begin
            chk($sformatf("rsp_valid[%0d]", i), rsp_valid[i], 1'b1);
            chk($sformatf("rsp_data[%0d]", i), rsp_data[i*DW +: DW], sb[hit].d);
            sb.delete(hit);
          end else chk($sformatf("rsp_idle[%0d]", i), rsp_valid[i], 1'b0);
        end
        for (int b = 0; b < NB; b++) begin
          chk($sformatf("bank_wr_en[%0d]", b), bank_wr_en[b], pw_en[b]);
          if (pw_en[b]) begin
            chk($sformatf("bank_wr_addr[%0d]", b), bank_wr_addr[b*BAW +: BAW], pw_a[b]);
            chk($sformatf("bank_wr_data[%0d]", b), bank_wr_data[b*DW +: DW], pw_d[b]);
          end
          chk($sformatf("bank_rd_en[%0d]", b), bank_rd_en[b], pr_en[b]);
          if (pr_en[b]) chk($sformatf("bank_rd_addr[%0d]", b), bank_rd_addr[b*BAW +: BAW], pr_a[b]);
        end
        pw_en = '0;
        pr_en = '0;
        // reads accepted this cycle see memory before this cycle's writes
        for (int i = 0; i < NR; i++) if (req_valid[i] && req_ready[i] && !req_we[i]) begin
          a = req_addr[i*AW +: AW];
          sb.push_back('{i, ref_mem[a], cyc + 3});
          pr_en[a[1:0]] = 1'b1;
          pr_a[a[1:0]]  = a[AW-1:2];
        end
        for (int i = 0; i < NR; i++) if (req_valid[i] && req_ready[i] && req_we[i]) begin
          a = req_addr[i*AW +: AW];
          ref_mem[a]    = req_wdata[i*DW +: DW];
          pw_en[a[1:0]] = 1'b1;
          pw_a[a[1:0]]  = a[AW-1:2];
          pw_d[a[1:0]]  = req_wdata[i*DW +: DW];
        end
      end
    end
  end

  typedef struct { logic [3:0] v, we; logic [19:0] a; logic [127:0] d; logic [3:0] rdy, wen, ren; } vec_t;
  vec_t tbl[$];

  function automatic void add(logic [3:0] v, we, logic [19:0] a, logic [127:0] d, logic [3:0] rdy, wen, ren);
    vec_t t;
    t.v = v; t.we = we; t.a = a; t.d = d; t.rdy = rdy; t.wen = wen; t.ren = ren;
    tbl.push_back(t);
  endfunction

  task automatic drive(input logic [3:0] v, we, input logic [19:0] a, input logic [127:0] d);
    req_valid = v; req_we = we; req_addr = a; req_wdata = d;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, req_ready, 4'h0);
    chk({tag, "_wr_en"}, bank_wr_en, 4'h0);
    chk({tag, "_rd_en"}, bank_rd_en, 4'h0);
    chk({tag, "_wr_addr"}, bank_wr_addr, '0);
    chk({tag, "_rd_addr"}, bank_rd_addr, '0);
    chk({tag, "_wr_data_lo"}, bank_wr_data[63:0], '0);
    chk({tag, "_rsp_valid"}, rsp_valid, 4'h0);
    chk({tag, "_rsp_data_lo"}, rsp_data[63:0], '0);
    chk({tag, "_rsp_data_hi"}, rsp_data[127:64], '0);
    chk({tag, "_stall"}, stall_count, 16'h0);
  endtask

  task automatic do_reset(input int hold);
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(4'h0, 4'h0, '0, '0);
    @(negedge clk);
    chk_reset("rst");
    repeat (hold) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

  localparam logic [127:0] CONF_D = {32'h103, 32'h102, 32'h101, 32'h100};

  initial begin
    for (int k = 0; k < NB*EPB; k++) ref_mem[k] = 32'hA000_0000 + k;
    //   v      we     addr {a3,a2,a1,a0}          wdata {d3,d2,d1,d0}                     rdy    wen    ren
    add(4'h0, 4'h0, '0,                           '0,                                     4'h0, 4'h0, 4'h0);
    add(4'h1, 4'h1, {15'd0, 5'd5},                {96'd0, 32'hDEADBEEF},                  4'h1, 4'h0, 4'h0);
    add(4'h1, 4'h0, {15'd0, 5'd5},                '0,                                     4'h1, 4'h2, 4'h0);
    add(4'h0, 4'h0, '0,                           '0,                                     4'h0, 4'h0, 4'h2);
    add(4'hF, 4'h0, {5'd3, 5'd2, 5'd1, 5'd0},     '0,                                     4'hF, 4'h0, 4'h0);
    add(4'hF, 4'hF, {4{5'd2}},                    CONF_D,                                 4'h1, 4'h0, 4'hF);
    add(4'hF, 4'hF, {4{5'd2}},                    CONF_D,                                 4'h2, 4'h4, 4'h0);
    add(4'hF, 4'hF, {4{5'd2}},                    CONF_D,                                 4'h4, 4'h4, 4'h0);
    add(4'hF, 4'hF, {4{5'd2}},                    CONF_D,                                 4'h8, 4'h4, 4'h0);
    add(4'hF, 4'hF, {4{5'd2}},                    CONF_D,                                 4'h1, 4'h4, 4'h0);
    add(4'h4, 4'h4, '0,                           {32'h0, 32'h22, 64'h0},                 4'h4, 4'h4, 4'h0);
    add(4'h3, 4'h2, '0,                           {64'h0, 32'h11, 32'h0},                 4'h3, 4'h1, 4'h0);
    add(4'h8, 4'h0, '0,                           '0,                                     4'h8, 4'h1, 4'h1);
    add(4'hA, 4'h0, {5'd7, 5'd0, 5'd3, 5'd0},     '0,                                     4'h2, 4'h0, 4'h1);
    add(4'hA, 4'h0, {5'd7, 5'd0, 5'd3, 5'd0},     '0,                                     4'h8, 4'h0, 4'h8);
    add(4'hF, 4'h9, {5'd4, 5'd1, 5'd6, 5'd1},     {32'h66, 64'h0, 32'h55},                4'hF, 4'h0, 4'h8);
    add(4'h0, 4'h0, '0,                           '0,                                     4'h0, 4'h3, 4'h6);
    for (int k = 0; k < 3; k++) add(4'h0, 4'h0, '0, '0, 4'h0, 4'h0, 4'h0);

    // reset held with requests pending: ready must stay low
    drive(4'hF, 4'h0, {5'd3, 5'd2, 5'd1, 5'd0}, '0);
    @(negedge clk);
    chk_reset("por");
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(4'h0, 4'h0, '0, '0);

    for (int k = 0; k < tbl.size(); k++) begin
      @(posedge clk); #1;
      drive(tbl[k].v, tbl[k].we, tbl[k].a, tbl[k].d);
      @(negedge clk);
      chk($sformatf("v%0d_ready", k), req_ready, tbl[k].rdy);
      chk($sformatf("v%0d_wr_en", k), bank_wr_en, tbl[k].wen);
      chk($sformatf("v%0d_rd_en", k), bank_rd_en, tbl[k].ren);
    end

    // continuous four-way write conflict on bank 2 from reset
    do_reset(2);
    drive(4'hF, 4'hF, {4{5'd2}}, {32'h203, 32'h202, 32'h201, 32'h200});
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("conf%0d_ready", k), req_ready, 4'b0001 << (k % 4));
      chk($sformatf("conf%0d_stall", k), stall_count, k);
    end
    repeat (70000) @(negedge clk);
    chk("stall_sat", stall_count, 16'hFFFF);
    repeat (3) @(negedge clk);
    chk("stall_sat_hold", stall_count, 16'hFFFF);

    // reset one cycle after a read accept; pointer of bank 0 would otherwise favour req1
    do_reset(1);
    drive(4'h1, 4'h0, '0, '0);
    @(negedge clk);
    chk("mid_accept", req_ready, 4'h1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(4'h3, 4'h0, {15'd0, 5'd4, 5'd0}, '0);
    @(negedge clk);
    chk_reset("mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ptr_restart", req_ready, 4'h1);
    @(posedge clk); #1;
    drive(4'h0, 4'h0, '0, '0);
    repeat (6) @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
